// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one memory access unit
//            between the instruction-fetch port and the load/store port.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic [3:0]  if_rsp_fault,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_is_write,
    input  logic        d_is_unsigned,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [3:0]  d_rsp_fault,
    output logic        mem_available,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_busy,
    input  logic        mem_op_fault,
    input  logic        mem_addr_fault,
    input  logic        mem_access_fault,
    output logic        busy
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q;
    logic           last_grant_q;   // 1 = data port
    logic           owner_q;        // 1 = data port
    logic [CNT_W-1:0] cnt_q;

    logic           mem_available_q;
    logic           mem_is_write_q;
    logic           mem_is_unsigned_q;
    logic [1:0]     mem_op_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_in_q;

    logic           if_rsp_valid_q;
    logic [31:0]    if_rsp_data_q;
    logic [3:0]     if_rsp_fault_q;
    logic           d_rsp_valid_q;
    logic [31:0]    d_rsp_data_q;
    logic [3:0]     d_rsp_fault_q;

    logic           w_grant_if;
    logic           w_grant_d;
    logic           w_timeout;
    logic           w_done;
    logic [31:0]    rsp_data_d;
    logic [3:0]     rsp_fault_d;

    // Ties go to whichever port did not win the previous grant.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (state_q == S_IDLE && !mem_busy) begin
            if (if_req_valid && d_req_valid) begin
                w_grant_d  = ~last_grant_q;
                w_grant_if = last_grant_q;
            end else begin
                w_grant_if = if_req_valid;
                w_grant_d  = d_req_valid;
            end
        end
    end

    assign w_timeout   = (TIMEOUT != 0) && mem_busy && (32'(cnt_q) == TIMEOUT);
    assign w_done      = !mem_busy || w_timeout;
    assign rsp_data_d  = mem_busy ? 32'h0 : mem_out;
    assign rsp_fault_d = mem_busy ? 4'b1000
                                  : {1'b0, mem_access_fault, mem_addr_fault, mem_op_fault};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            last_grant_q      <= 1'b0;
            owner_q           <= 1'b0;
            cnt_q             <= '0;
            mem_available_q   <= 1'b0;
            mem_is_write_q    <= 1'b0;
            mem_is_unsigned_q <= 1'b0;
            mem_op_q          <= 2'b00;
            mem_addr_q        <= 32'h0;
            mem_in_q          <= 32'h0;
            if_rsp_valid_q    <= 1'b0;
            if_rsp_data_q     <= 32'h0;
            if_rsp_fault_q    <= 4'h0;
            d_rsp_valid_q     <= 1'b0;
            d_rsp_data_q      <= 32'h0;
            d_rsp_fault_q     <= 4'h0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_grant_if || w_grant_d) begin
                        owner_q           <= w_grant_d;
                        last_grant_q      <= w_grant_d;
                        mem_available_q   <= 1'b1;
                        mem_addr_q        <= w_grant_d ? d_addr : if_addr;
                        mem_op_q          <= w_grant_d ? d_op : 2'b10;
                        mem_is_write_q    <= w_grant_d & d_is_write;
                        mem_is_unsigned_q <= w_grant_d & d_is_unsigned;
                        mem_in_q          <= w_grant_d ? d_wdata : 32'h0;
                        state_q           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        // Dropping mem_available here gives the unit its idle re-arm cycle.
                        mem_available_q <= 1'b0;
                        state_q         <= S_RESP;
                        if (owner_q) begin
                            d_rsp_valid_q <= 1'b1;
                            d_rsp_data_q  <= rsp_data_d;
                            d_rsp_fault_q <= rsp_fault_d;
                        end else begin
                            if_rsp_valid_q <= 1'b1;
                            if_rsp_data_q  <= rsp_data_d;
                            if_rsp_fault_q <= rsp_fault_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_req_ready    = w_grant_if;
    assign d_req_ready     = w_grant_d;
    assign if_rsp_valid    = if_rsp_valid_q;
    assign if_rsp_data     = if_rsp_data_q;
    assign if_rsp_fault    = if_rsp_fault_q;
    assign d_rsp_valid     = d_rsp_valid_q;
    assign d_rsp_data      = d_rsp_data_q;
    assign d_rsp_fault     = d_rsp_fault_q;
    assign mem_available   = mem_available_q;
    assign mem_is_write    = mem_is_write_q;
    assign mem_is_unsigned = mem_is_unsigned_q;
    assign mem_op          = mem_op_q;
    assign mem_addr        = mem_addr_q;
    assign mem_in          = mem_in_q;
    assign busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a behavioural memory unit.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic [3:0]  if_rsp_fault;
    logic        d_req_valid, d_req_ready, d_is_write, d_is_unsigned, d_rsp_valid;
    logic [1:0]  d_op;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [3:0]  d_rsp_fault;
    logic        mem_available, mem_is_write, mem_is_unsigned;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_busy, mem_op_fault, mem_addr_fault, mem_access_fault;
    logic        busy;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_fault(if_rsp_fault),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_is_write(d_is_write),
        .d_is_unsigned(d_is_unsigned), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_fault(d_rsp_fault),
        .mem_available(mem_available), .mem_is_write(mem_is_write),
        .mem_is_unsigned(mem_is_unsigned), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out), .mem_busy(mem_busy),
        .mem_op_fault(mem_op_fault), .mem_addr_fault(mem_addr_fault),
        .mem_access_fault(mem_access_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errs   = 0;
    int g_t      = 0;

    // Per-access behaviour of the memory unit, chosen by the stimulus side.
    int          m_n_cfg = 0;
    logic [31:0] m_data_cfg = 32'h0;
    logic [2:0]  m_flt_cfg = 3'b000;

    // Memory unit: busy for m_n_cfg cycles starting the cycle after ISSUE.
    initial begin : mem_unit
        int   pending;
        logic prev_av;
        pending = 0;
        prev_av = 1'b0;
        mem_busy = 1'b0; mem_out = 32'h0;
        mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                pending = 0; mem_busy = 1'b0; prev_av = 1'b0;
            end else begin
                if (mem_available && !prev_av) begin
                    pending = m_n_cfg;
                    mem_out = m_data_cfg;
                    {mem_access_fault, mem_addr_fault, mem_op_fault} = m_flt_cfg;
                    mem_busy = 1'b0;
                end else if (pending > 0) begin
                    mem_busy = 1'b1;
                    pending--;
                end else begin
                    mem_busy = 1'b0;
                end
                prev_av = mem_available;
            end
        end
    end

    typedef struct {
        logic        ifv, dv;
        logic [31:0] ia, da, wd;
        logic [1:0]  op;
        logic        wr, us;
        int          n;
        logic [31:0] mdata;
        logic [2:0]  mflt;
        logic        exp_d;
        int          exp_lat;
        logic [3:0]  exp_flt;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    vec_t vecs[8];

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (if_rsp_valid || d_rsp_valid) begin
                got = 1'b1;
                break;
            end
            next_cycle(); settle();
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        bit got;
        int t;
        m_n_cfg = v.n; m_data_cfg = v.mdata; m_flt_cfg = v.mflt;
        if_req_valid = v.ifv; if_addr = v.ia;
        d_req_valid = v.dv; d_addr = v.da; d_wdata = v.wd; d_op = v.op;
        d_is_write = v.wr; d_is_unsigned = v.us;
        settle();
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (if_req_ready || d_req_ready) begin
                got = 1'b1;
                break;
            end
            next_cycle(); settle();
        end
        if (!got) begin
            chk($sformatf("v%0d_grant_wait", idx), 32'd0, 32'd1);
            if_req_valid = 1'b0; d_req_valid = 1'b0;
            return;
        end
        chk($sformatf("v%0d_grant", idx), {30'd0, d_req_ready, if_req_ready},
            {30'd0, v.exp_d, ~v.exp_d});
        t = cyc;
        g_t = t;
        next_cycle();
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        settle();
        chk($sformatf("v%0d_issue_avail", idx), 32'(mem_available), 32'd1);
        chk($sformatf("v%0d_issue_addr", idx), mem_addr, v.exp_d ? v.da : v.ia);
        chk($sformatf("v%0d_issue_op", idx), 32'(mem_op), 32'(v.exp_d ? v.op : 2'b10));
        wait_rsp(got);
        if (!got) begin
            chk($sformatf("v%0d_rsp_wait", idx), 32'd0, 32'd1);
            return;
        end
        chk($sformatf("v%0d_rsp_port", idx), {30'd0, d_rsp_valid, if_rsp_valid},
            {30'd0, v.exp_d, ~v.exp_d});
        chk($sformatf("v%0d_latency", idx), 32'(cyc - t), 32'(v.exp_lat));
        chk($sformatf("v%0d_fault", idx), 32'(v.exp_d ? d_rsp_fault : if_rsp_fault),
            32'(v.exp_flt));
        if (v.chk_data)
            chk($sformatf("v%0d_data", idx), v.exp_d ? d_rsp_data : if_rsp_data, v.exp_data);
        next_cycle(); settle();
        chk($sformatf("v%0d_rsp_once", idx), {30'd0, d_rsp_valid, if_rsp_valid}, 32'd0);
    endtask

    // Random-phase reference model state.
    bit          pend_if, pend_d, m_last_d, e_grant, e_d, have_txn, tmo, r_d;
    int          m_free, gcyc, rsp_cyc, rn, viol;
    logic [3:0]  r_flt;
    logic [31:0] r_data, r_addr, r_wdata;
    logic [1:0]  r_op;
    logic        r_wr, r_us;

    initial begin
        vec_t vb;
        bit   got;
        reset_n = 1'b0;
        if_req_valid = 1'b0; if_addr = 32'h0;
        d_req_valid = 1'b0; d_is_write = 1'b0; d_is_unsigned = 1'b0;
        d_op = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;

        //          ifv   dv    ia          da          wd          op     wr    us    n   mdata        mflt    exp_d lat flt      data         chk
        vecs[0] = '{1'b1, 1'b0, 32'h100,    32'h0,      32'h0,      2'b10, 1'b0, 1'b0, 3,  32'hDEADBEEF, 3'b000, 1'b0, 6,  4'b0000, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h200,    32'h300,    32'h0,      2'b10, 1'b0, 1'b0, 1,  32'h11111111, 3'b000, 1'b1, 4,  4'b0000, 32'h11111111, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h204,    32'h304,    32'h0,      2'b10, 1'b0, 1'b0, 1,  32'h22222222, 3'b000, 1'b0, 4,  4'b0000, 32'h22222222, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h208,    32'h308,    32'h0,      2'b00, 1'b0, 1'b1, 1,  32'h33333333, 3'b000, 1'b1, 4,  4'b0000, 32'h33333333, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h20C,    32'h30C,    32'h0,      2'b10, 1'b0, 1'b0, 1,  32'h44444444, 3'b000, 1'b0, 4,  4'b0000, 32'h44444444, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h0,      32'h101,    32'h0,      2'b01, 1'b0, 1'b0, 0,  32'h0,        3'b110, 1'b1, 3,  4'b0110, 32'h0,        1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0,      32'h400,    32'h0,      2'b11, 1'b0, 1'b0, 0,  32'h0,        3'b001, 1'b1, 3,  4'b0001, 32'h0,        1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h500,    32'h0,      32'h0,      2'b10, 1'b0, 1'b0, 20, 32'h55555555, 3'b000, 1'b0, 11, 4'b1000, 32'h0,        1'b1};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        settle();
        chk("reset_ready", {30'd0, d_req_ready, if_req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, d_rsp_valid, if_rsp_valid}, 32'd0);
        chk("reset_mem_ctl", {28'd0, mem_available, mem_is_write, mem_is_unsigned, busy}, 32'd0);
        chk("reset_mem_op", 32'(mem_op), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_in", mem_in, 32'd0);
        chk("reset_rsp_data", if_rsp_data | d_rsp_data, 32'd0);
        chk("reset_rsp_fault", 32'({if_rsp_fault, d_rsp_fault}), 32'd0);

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // A pending request must wait until the stuck unit finally drops mem_busy.
        m_n_cfg = 2; m_data_cfg = 32'h0BADF00D; m_flt_cfg = 3'b000;
        d_req_valid = 1'b1; d_addr = 32'h800; d_op = 2'b10; d_is_write = 1'b0;
        settle();
        viol = 0;
        for (int k = 0; k < 64 && cyc < g_t + 22; k++) begin
            if (d_req_ready || if_req_ready) viol++;
            next_cycle(); settle();
        end
        chk("stuck_no_grant", 32'(viol), 32'd0);
        chk("stuck_grant_cycle", 32'(cyc - g_t), 32'd22);
        chk("stuck_grant", 32'(d_req_ready), 32'd1);
        g_t = cyc;
        next_cycle(); d_req_valid = 1'b0; settle();
        wait_rsp(got);
        chk("stuck_rsp_latency", 32'(got ? cyc - g_t : -1), 32'd5);
        chk("stuck_rsp_data", d_rsp_data, 32'h0BADF00D);
        next_cycle(); settle();

        // Reset while the access sits in WAIT.
        m_n_cfg = 6; m_data_cfg = 32'h66666666;
        if_req_valid = 1'b1; if_addr = 32'h600;
        settle();
        chk("rstw_grant", 32'(if_req_ready), 32'd1);
        next_cycle(); if_req_valid = 1'b0;
        next_cycle(); next_cycle();
        reset_n = 1'b0;
        #1;
        chk("rstw_avail", 32'(mem_available), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        next_cycle(); next_cycle();
        reset_n = 1'b1;
        settle();
        chk("rstw_addr_cleared", mem_addr, 32'd0);
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            if (if_rsp_valid || d_rsp_valid) viol++;
            next_cycle(); settle();
        end
        chk("rstw_no_rsp", 32'(viol), 32'd0);
        vb = '{1'b1, 1'b0, 32'h700, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 2,
               32'hCAFEF00D, 3'b000, 1'b0, 5, 4'b0000, 32'hCAFEF00D, 1'b1};
        run_txn(8, vb);

        // Randomised traffic against a cycle-accurate transaction model.
        pend_if = 1'b0; pend_d = 1'b0; m_last_d = 1'b0; have_txn = 1'b0;
        m_free = cyc; gcyc = cyc; rsp_cyc = cyc;
        r_d = 1'b0; r_flt = 4'h0; r_data = 32'h0; r_addr = 32'h0; r_wdata = 32'h0;
        r_op = 2'b00; r_wr = 1'b0; r_us = 1'b0; tmo = 1'b0;
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            if (!pend_if && $urandom_range(2) == 0) begin
                pend_if = 1'b1; if_addr = $urandom;
            end
            if (!pend_d && $urandom_range(2) == 0) begin
                pend_d = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_op = 2'($urandom_range(3));
                d_is_write = 1'($urandom_range(1));
                d_is_unsigned = 1'($urandom_range(1));
            end
            if_req_valid = pend_if; d_req_valid = pend_d;
            settle();
            e_grant = (cyc >= m_free) && !mem_busy && (pend_if || pend_d);
            e_d     = pend_d && (!pend_if || !m_last_d);
            chk("rnd_ready", {30'd0, d_req_ready, if_req_ready},
                e_grant ? {30'd0, e_d, ~e_d} : 32'd0);
            chk("rnd_rsp_valid", {30'd0, d_rsp_valid, if_rsp_valid},
                (have_txn && cyc == rsp_cyc) ? {30'd0, r_d, ~r_d} : 32'd0);
            chk("rnd_busy", 32'(busy), 32'(have_txn && cyc > gcyc && cyc < m_free));
            chk("rnd_avail", 32'(mem_available), 32'(have_txn && cyc > gcyc && cyc < rsp_cyc));
            if (have_txn && cyc == gcyc + 1) begin
                chk("rnd_issue_addr", mem_addr, r_addr);
                chk("rnd_issue_attr", {28'd0, mem_op, mem_is_write, mem_is_unsigned},
                    {28'd0, r_op, r_wr, r_us});
                if (r_d) chk("rnd_issue_wdata", mem_in, r_wdata);
            end
            if (have_txn && cyc == rsp_cyc) begin
                chk("rnd_fault", 32'(r_d ? d_rsp_fault : if_rsp_fault), 32'(r_flt));
                if (r_flt == 4'h0 || tmo)
                    chk("rnd_data", r_d ? d_rsp_data : if_rsp_data, r_data);
            end
            if (e_grant) begin
                rn = $urandom_range(11);
                m_n_cfg = rn;
                m_data_cfg = $urandom;
                m_flt_cfg = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b000;
                tmo = (rn > TMO);
                have_txn = 1'b1;
                gcyc = cyc;
                rsp_cyc = cyc + 3 + (tmo ? TMO : rn);
                m_free = rsp_cyc + 1;
                r_d = e_d;
                r_flt = tmo ? 4'b1000 : {1'b0, m_flt_cfg};
                r_data = tmo ? 32'h0 : m_data_cfg;
                r_addr = e_d ? d_addr : if_addr;
                r_op = e_d ? d_op : 2'b10;
                r_wr = e_d & d_is_write;
                r_us = e_d & d_is_unsigned;
                r_wdata = d_wdata;
                m_last_d = e_d;
                if (e_d) pend_d = 1'b0;
                else pend_if = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
